// File: rtl/ps2_hex_char_fifo.sv
// PS/2 keyboard front end: frame receiver, make/break decoder for the hex
// keypad (0-9, A-F) and a first-word fall-through character FIFO.
module ps2_hex_char_fifo #(
  parameter int CHAR_W      = 4,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kb_clock,
  input  logic              data,
  input  logic              rd_en,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Make code to hex digit; bit 4 flags a mapped key.
  function automatic logic [4:0] map_code(input logic [7:0] b);
    case (b)
      8'h45:   map_code = {1'b1, 4'd0};
      8'h16:   map_code = {1'b1, 4'd1};
      8'h1E:   map_code = {1'b1, 4'd2};
      8'h26:   map_code = {1'b1, 4'd3};
      8'h25:   map_code = {1'b1, 4'd4};
      8'h2E:   map_code = {1'b1, 4'd5};
      8'h36:   map_code = {1'b1, 4'd6};
      8'h3D:   map_code = {1'b1, 4'd7};
      8'h3E:   map_code = {1'b1, 4'd8};
      8'h46:   map_code = {1'b1, 4'd9};
      8'h1C:   map_code = {1'b1, 4'd10};
      8'h32:   map_code = {1'b1, 4'd11};
      8'h21:   map_code = {1'b1, 4'd12};
      8'h23:   map_code = {1'b1, 4'd13};
      8'h24:   map_code = {1'b1, 4'd14};
      8'h2B:   map_code = {1'b1, 4'd15};
      default: map_code = {1'b0, 4'd0};
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] kb_sync_q, kb_sync_d, dat_sync_q, dat_sync_d;
  logic                   kb_prev_q, edge_q, edge_d;
  logic                   kb_s, data_s;
  state_t                 state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d, byte_q, byte_d;
  logic                   par_q, par_d, byte_vld_q, byte_vld_d;
  logic                   parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   brk_q, brk_d, ext_q, ext_d;
  logic [4:0]             map_s;
  logic                   push_s, pop_s, push_ok_s;
  logic [CHAR_W-1:0]      code_ext_s;
  logic [CHAR_W-1:0]      mem_q [DEPTH];
  logic [CHAR_W-1:0]      mem_d [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   overflow_q, overflow_d;

  assign kb_s   = kb_sync_q[SYNC_STAGES-1];
  assign data_s = dat_sync_q[SYNC_STAGES-1];

  // Synchroniser shift and registered falling-edge detect on kb_clock.
  always_comb begin
    kb_sync_d  = {kb_sync_q[SYNC_STAGES-2:0], kb_clock};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], data};
    edge_d     = kb_prev_q & ~kb_s;
  end

  // Frame FSM, watchdog and stop-bit checking.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_d       = byte_q;
    byte_vld_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == S_IDLE || edge_q) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
    if (edge_q) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: begin
          par_d   = data_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          // A bad stop bit masks a bad parity bit.
          if (!data_s) begin
            frame_err_d = 1'b1;
          end else if (^{par_q, shift_q} == 1'b0) begin
            parity_err_d = 1'b1;
          end else begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && wd_q >= WD_W'(TIMEOUT)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // Break/extended prefix tracking and hex lookup on accepted bytes.
  always_comb begin
    brk_d      = brk_q;
    ext_d      = ext_q;
    push_s     = 1'b0;
    map_s      = map_code(byte_q);
    code_ext_s = '0;
    code_ext_s[3:0] = map_s[3:0];
    if (byte_vld_q) begin
      if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        push_s = map_s[4];
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO pointer, occupancy and storage update.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop_s      = rd_en && (count_q != '0);
    push_ok_s  = push_s && ((count_q != (ADDR_W+1)'(DEPTH)) || pop_s);
    if (push_s && !push_ok_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = code_ext_s;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_s) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop_s && !push_ok_s) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers; the PS/2 lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_sync_q    <= '1;
      dat_sync_q   <= '1;
      kb_prev_q    <= 1'b1;
      edge_q       <= 1'b0;
      state_q      <= S_IDLE;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      byte_q       <= 8'h00;
      byte_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wd_q         <= '0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      kb_sync_q    <= kb_sync_d;
      dat_sync_q   <= dat_sync_d;
      kb_prev_q    <= kb_s;
      edge_q       <= edge_d;
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      byte_q       <= byte_d;
      byte_vld_q   <= byte_vld_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      wd_q         <= wd_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign char       = mem_q[rd_ptr_q];
  assign char_valid = (count_q != '0);
  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
